// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcode constants and the
// fetch-stage state type.
package mips_pkg;

    // I-type and R-type opcodes, taken from inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Fetch-stage states: reset parking, request outstanding, word held
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Request/ready handshake between the fetch stage and instruction memory.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    // Fetch stage drives the request side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    // Instruction memory answers
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/imm_ext_ctrl.sv
// Immediate extender mode decode: opcode -> sign (1) or zero (0) extension.
// Shared with the main control unit.
module imm_ext_ctrl
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       sext
);

    // Arithmetic, compare, branch and load/store immediates are signed;
    // logical immediates, lui, R-type and anything unknown are zero-extended
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        sext = 1'b0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ,  OP_BNE,   OP_LW,   OP_SW:   sext = 1'b1;
            default:                            sext = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM and instruction register.
// Every output is a function of registered state only.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic [31:0]               inst,
    output logic                      inst_valid,
    output logic [15:0]               inst15_0,
    output logic                      sext
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  redirect_target;
    logic         unused_redirect_lsbs;

    // Redirect targets are word aligned; the two low bits are dropped
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    // Next-state, next-PC and instruction capture decisions
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect belongs to the
                    // old path and is discarded
                    pc_d = redirect_target;
                end else if (imem.imem_ready) begin
                    inst_d  = imem.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and instruction registers; reset parks the stage in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of ordering.
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign inst       = inst_q;
    assign inst_valid = (state_q == HOLD);
    assign inst15_0   = inst_q[15:0];

    imm_ext_ctrl u_imm_ext_ctrl (
        .opcode (inst_q[31:26]),
        .sext   (sext)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized handshake traffic, all compared against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc, pc_plus4, inst;
    logic        inst_valid, sext;
    logic [15:0] inst15_0;

    int vectors = 0;
    int errors  = 0;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst15_0       (inst15_0),
        .sext           (sext)
    );

    always #5 clk = ~clk;

    // Reference model: started = left reset parking, waiting = a request is
    // outstanding, holding = a word is presented downstream
    logic        m_started, m_waiting, m_holding;
    logic [31:0] m_pc, m_inst;

    function automatic logic model_sext(input logic [31:0] word);
        logic [5:0] op;
        op = word[31:26];
        return op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B};
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_waiting = 1'b0;
        m_holding = 1'b0;
        m_pc      = 32'h0000_0000;
        m_inst    = 32'd0;
    endtask

    // Applies one clock edge's worth of the fetch rules to the model
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
            m_waiting = 1'b1;
        end else if (m_waiting) begin
            if (redirect_valid) begin
                m_pc = redirect_pc & ~32'd3;
            end else if (imem_bus.imem_ready) begin
                m_inst    = imem_bus.imem_rdata;
                m_waiting = 1'b0;
                m_holding = 1'b1;
            end
        end else if (m_holding) begin
            if (redirect_valid || !stall) begin
                m_pc      = redirect_valid ? (redirect_pc & ~32'd3) : m_pc + 32'd4;
                m_holding = 1'b0;
                m_waiting = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_model();
        check("imem_req",   {31'd0, imem_bus.imem_req}, {31'd0, m_waiting});
        check("imem_addr",  imem_bus.imem_addr, m_pc);
        check("pc",         pc, m_pc);
        check("pc_plus4",   pc_plus4, m_pc + 32'd4);
        check("inst",       inst, m_inst);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_holding});
        check("inst15_0",   {16'd0, inst15_0}, {16'd0, m_inst[15:0]});
        check("sext",       {31'd0, sext}, {31'd0, model_sext(m_inst)});
    endtask

    // One clock: inputs are already stable; sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic stl,
                         input logic rv, input logic [31:0] rpc);
        imem_bus.imem_ready = rdy;
        imem_bus.imem_rdata = rdata;
        stall               = stl;
        redirect_valid      = rv;
        redirect_pc         = rpc;
    endtask

    initial begin
        model_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset state
        #3;
        check_model();
        check("reset_pc", pc, 32'h0000_0000);
        check("reset_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // addi with zero-wait memory
        drive(1'b1, 32'h2008_FFFF, 1'b0, 1'b0, 32'd0);
        tick();
        check("first_fetch_addr", imem_bus.imem_addr, 32'h0000_0000);
        tick();
        check("addi_valid", {31'd0, inst_valid}, 32'd1);
        check("addi_imm", {16'd0, inst15_0}, 32'h0000_FFFF);
        check("addi_sext", {31'd0, sext}, 32'd1);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("pc_after_addi", pc, 32'h0000_0004);

        // ori is zero-extended
        drive(1'b1, 32'h3401_8000, 1'b0, 1'b0, 32'd0);
        tick();
        check("ori_sext", {31'd0, sext}, 32'd0);
        check("ori_imm", {16'd0, inst15_0}, 32'h0000_8000);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();

        // Memory wait states at pc=8
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr", imem_bus.imem_addr, 32'h0000_0008);
        end
        drive(1'b1, 32'h8C22_0010, 1'b0, 1'b0, 32'd0);
        tick();
        check("valid_after_wait", {31'd0, inst_valid}, 32'd1);

        // Stall in HOLD for 4 cycles, then advance
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("stall_pc", pc, 32'h0000_0008);
        check("stall_inst", inst, 32'h8C22_0010);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("pc_after_stall", pc, 32'h0000_000C);

        // Redirect beats stall in HOLD; low address bits are forced to 0
        drive(1'b1, 32'h1000_0001, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0103);
        tick();
        check("redirect_addr", imem_bus.imem_addr, 32'h0000_0100);
        check("redirect_drop", {31'd0, inst_valid}, 32'd0);

        // Redirect in FETCH to the top word, with a coincident ready discarded
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        check("top_pc", pc, 32'hFFFF_FFFC);

        // Asynchronous reset mid-FETCH takes effect without a clock edge
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        check("async_rst_pc", pc, 32'h0000_0000);
        check("async_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PC wraps from FFFF_FFFC to 0
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("pc_wrap", pc, 32'h0000_0000);

        // Randomized handshake traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom());
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
